// File: rtl/key_expansion.sv
// AES-128 key schedule stepped one round key per ready pulse.
// Output is combinational and gated by ready. The block advances on the falling edge of ready.

module key_expansion_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  always_comb begin
    s = 8'h00;
    case (a)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
    endcase
  end
endmodule

module key_expansion (
  input  logic         clk,
  input  logic         rst,
  input  logic         ready,
  input  logic [127:0] key_in,
  output logic [3:0]   index,
  output logic [127:0] round_key
);
  logic [3:0]   idx;
  logic [127:0] key_reg;
  logic         ready_q;
  logic [127:0] prev;
  logic [31:0]  rot;
  logic [31:0]  sub;
  logic [7:0]   rcon;
  logic [31:0]  t, n0, n1, n2, n3;
  logic         advance;

  // Round 0 is always taken straight from key_in, so key_reg is never consulted there.
  assign prev    = (idx == 4'd0) ? key_in : key_reg;
  assign rot     = {prev[23:0], prev[31:24]};
  assign advance = ready_q & ~ready;

  key_expansion_sbox u_sbox0 (.a(rot[31:24]), .s(sub[31:24]));
  key_expansion_sbox u_sbox1 (.a(rot[23:16]), .s(sub[23:16]));
  key_expansion_sbox u_sbox2 (.a(rot[15:8]),  .s(sub[15:8]));
  key_expansion_sbox u_sbox3 (.a(rot[7:0]),   .s(sub[7:0]));

  always_comb begin
    rcon = 8'h00;
    case (idx)
      4'd0: rcon = 8'h01;
      4'd1: rcon = 8'h02;
      4'd2: rcon = 8'h04;
      4'd3: rcon = 8'h08;
      4'd4: rcon = 8'h10;
      4'd5: rcon = 8'h20;
      4'd6: rcon = 8'h40;
      4'd7: rcon = 8'h80;
      4'd8: rcon = 8'h1b;
      4'd9: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t  = sub ^ {rcon, 24'h000000};
  assign n0 = prev[127:96] ^ t;
  assign n1 = prev[95:64]  ^ n0;
  assign n2 = prev[63:32]  ^ n1;
  assign n3 = prev[31:0]   ^ n2;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= 4'd0;
      key_reg <= 128'h0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= ready;
      if (advance) begin
        if (idx == 4'd10) begin
          idx <= 4'd0;
        end else begin
          key_reg <= {n0, n1, n2, n3};
          idx     <= idx + 4'd1;
        end
      end
    end
  end

  assign index     = ready ? idx : 4'd0;
  assign round_key = ready ? ((idx == 4'd0) ? key_in : key_reg) : 128'h0;
endmodule

// File: tb/tb_key_expansion.sv
// Scoreboard bench for key_expansion: driver pushes expected {index, round_key} per ready-high cycle,
// monitor pops and compares; reference schedule is computed from GF(2^8) arithmetic.

module tb_key_expansion;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ready = 1'b0;
  logic [127:0] key_in = 128'h0;
  logic [3:0]   index;
  logic [127:0] round_key;

  int vectors = 0;
  int miscompares = 0;
  logic [131:0] exp_q[$];

  logic [7:0]   sbox_ref[256];
  logic [127:0] sched[11];
  int           pos = 0;

  key_expansion dut (
    .clk(clk), .rst(rst), .ready(ready), .key_in(key_in),
    .index(index), .round_key(round_key)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box = multiplicative inverse (a^254) followed by the FIPS-197 affine map.
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h01;
      logic [7:0] av = a[7:0];
      for (int k = 0; k < 254; k++) inv = gmul(inv, av);
      if (a == 0) inv = 8'h00;
      sbox_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic compute_sched(input logic [127:0] k);
    logic [31:0] w[44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_ref[tmp[31:24]], sbox_ref[tmp[23:16]], sbox_ref[tmp[15:8]], sbox_ref[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Enter and leave at posedge+1. One pulse: ready high for 'hold' edges, then low for 'gap' edges.
  task automatic pulse(input int hold, input int gap, input bit rst_fall,
                       input bit use_lit, input logic [3:0] lit_idx, input logic [127:0] lit_key);
    logic [131:0] e;
    if (use_lit) e = {lit_idx, lit_key};
    else e = {pos[3:0], (pos == 0) ? key_in : sched[pos]};
    for (int h = 0; h < hold; h++) exp_q.push_back(e);
    ready = 1'b1;
    repeat (hold) begin @(posedge clk); #1; end
    ready = 1'b0;
    rst = rst_fall;
    @(posedge clk); #1;
    rst = 1'b0;
    if (rst_fall) pos = 0;
    else begin
      if (pos == 0) compute_sched(key_in);
      pos = (pos == 10) ? 0 : pos + 1;
    end
    repeat (gap - 1) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pos = 0;
  endtask

  always @(negedge clk) begin
    logic [131:0] e;
    if (ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: got index=%0d key=%h, required no output pending", index, round_key);
      end else begin
        e = exp_q.pop_front();
        if (index !== e[131:128] || round_key !== e[127:0]) begin
          miscompares++;
          $display("FAIL round_key: got index=%0d key=%h, required index=%0d key=%h",
                   index, round_key, e[131:128], e[127:0]);
        end
      end
    end else begin
      vectors++;
      if (index !== 4'd0 || round_key !== 128'h0) begin
        miscompares++;
        $display("FAIL idle_zero: got index=%0d key=%h, required index=0 key=0", index, round_key);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // FIPS-197 appendix key: full walk, hold at K10, wrap, then K1 again.
    key_in = 128'h000102030405060708090a0b0c0d0e0f;
    pulse(1, 1, 0, 1, 4'd0, 128'h000102030405060708090a0b0c0d0e0f);
    pulse(2, 2, 0, 1, 4'd1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    for (int i = 2; i < 10; i++) pulse(1, 1, 0, 0, 4'd0, 128'h0);
    pulse(5, 2, 0, 1, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    pulse(1, 1, 0, 1, 4'd0, 128'h000102030405060708090a0b0c0d0e0f);
    pulse(1, 1, 0, 1, 4'd1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    for (int i = 2; i <= 4; i++) pulse(1, 1, 0, 0, 4'd0, 128'h0);
    do_reset();
    pulse(1, 1, 0, 1, 4'd0, 128'h000102030405060708090a0b0c0d0e0f);

    // Second known-answer key.
    do_reset();
    key_in = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    pulse(1, 1, 0, 1, 4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    pulse(1, 1, 0, 1, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
    for (int i = 2; i < 10; i++) pulse(1, 1, 0, 0, 4'd0, 128'h0);
    pulse(3, 1, 0, 1, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Reset coinciding with the falling edge of ready must swallow the advance.
    pulse(1, 1, 0, 1, 4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    pulse(1, 1, 1, 1, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
    pulse(1, 1, 0, 1, 4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);

    // Random keys, holds, gaps, resets; key_in also changes mid-sequence.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) do_reset();
      if ($urandom_range(0, 3) == 0) key_in = {$urandom, $urandom, $urandom, $urandom};
      pulse($urandom_range(1, 4), $urandom_range(1, 3), ($urandom_range(0, 19) == 0), 0, 4'd0, 128'h0);
    end

    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
